// File: rtl/vreg_group_addr_gen_if.sv
// Request/beat bundle between an instruction issue stage and the register-group address generator.
// Optional port `widen` exists only when VREG_AGU_WIDEN_EN is defined.
interface vreg_group_addr_gen_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_PORTS  = 3
);
  logic                            in_valid;
  logic                            in_ready;
  logic [2:0]                      vlmul;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_in;
  logic [NUM_PORTS-1:0]            port_en;
`ifdef VREG_AGU_WIDEN_EN
  logic [NUM_PORTS-1:0]            widen;
`endif
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_out;
  logic [NUM_PORTS-1:0]            out_port_en;
  logic                            out_first;
  logic                            out_last;
  logic                            err_misaligned;
  logic                            idle;

  modport master (
    output in_valid, vlmul, addr_in, port_en,
`ifdef VREG_AGU_WIDEN_EN
    output widen,
`endif
    output out_ready,
    input  in_ready, out_valid, addr_out, out_port_en, out_first, out_last,
    input  err_misaligned, idle
  );

  modport slave (
    input  in_valid, vlmul, addr_in, port_en,
`ifdef VREG_AGU_WIDEN_EN
    input  widen,
`endif
    input  out_ready,
    output in_ready, out_valid, addr_out, out_port_en, out_first, out_last,
    output err_misaligned, idle
  );
endinterface

// File: rtl/vreg_group_addr_gen.sv
// Walks every register of each operand's LMUL group in lock-step, one beat per cycle, with handshakes.
// Optional widening support (EMUL = 2*LMUL on selected ports) is enabled by defining VREG_AGU_WIDEN_EN.
module vreg_group_addr_gen #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_PORTS  = 3,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  vreg_group_addr_gen_if.slave  bus
);
  localparam int GW = ADDR_WIDTH + 2;

  typedef enum logic [0:0] {S_IDLE, S_BUSY} state_e;

  state_e                          state_q;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] base_q;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_out_q;
  logic [NUM_PORTS-1:0]            port_en_q;
  logic [CNT_WIDTH-1:0]            cnt_q;
  logic [CNT_WIDTH-1:0]            last_idx_q;
  logic                            first_q;
  logic                            last_q;
  logic                            err_q;
`ifdef VREG_AGU_WIDEN_EN
  logic [NUM_PORTS-1:0]            wide_q;
  logic                            half_q;
`endif

  logic                            accept_d;
  logic                            beat_take_d;
  logic                            req_legal_d;
  logic                            reserved_d;
  logic                            frac_d;
  logic                            any_wide_d;
  logic [NUM_PORTS-1:0]            req_wide_d;
  logic [NUM_PORTS-1:0]            lane_ok_d;
  logic [GW-1:0]                   unit_sz_d;
  logic [GW-1:0]                   req_n_d;
  logic [CNT_WIDTH-1:0]            req_last_idx_d;
  logic [CNT_WIDTH-1:0]            cnt_inc_d;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_adv_d;

`ifdef VREG_AGU_WIDEN_EN
  assign req_wide_d = bus.widen & bus.port_en;
`else
  assign req_wide_d = '0;
`endif
  assign any_wide_d = |req_wide_d;

  // Fractional encodings share vlmul[2]; the reserved 100 is caught separately as illegal.
  always_comb begin
    reserved_d     = (bus.vlmul == 3'b100);
    frac_d         = bus.vlmul[2];
    unit_sz_d      = frac_d ? GW'(1) : (GW'(1) << bus.vlmul[1:0]);
    req_n_d        = (any_wide_d && !frac_d) ? (unit_sz_d << 1) : unit_sz_d;
    req_last_idx_d = CNT_WIDTH'(req_n_d - GW'(1));
    req_legal_d    = !reserved_d && (&lane_ok_d)
                     && !(any_wide_d && (bus.vlmul == 3'b011));
  end

  assign bus.in_ready = (state_q == S_IDLE) || (bus.out_ready && last_q);
  assign accept_d     = bus.in_valid && bus.in_ready;
  assign beat_take_d  = (state_q == S_BUSY) && bus.out_ready;
  assign cnt_inc_d    = cnt_q + CNT_WIDTH'(1);

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_lane
      logic [GW-1:0]         grp_sz;
      logic [ADDR_WIDTH-1:0] grp_mask;
      logic [CNT_WIDTH-1:0]  lane_off;

      assign grp_sz   = (req_wide_d[gi] && !frac_d) ? (unit_sz_d << 1) : unit_sz_d;
      assign grp_mask = ADDR_WIDTH'(grp_sz - GW'(1));
      assign lane_ok_d[gi] = !bus.port_en[gi]
          || ((bus.addr_in[gi*ADDR_WIDTH +: ADDR_WIDTH] & grp_mask) == '0);

`ifdef VREG_AGU_WIDEN_EN
      // Narrow operands of a widening op step once per two beats.
      assign lane_off = (!half_q || wide_q[gi]) ? cnt_inc_d : (cnt_inc_d >> 1);
`else
      assign lane_off = cnt_inc_d;
`endif

      assign addr_adv_d[gi*ADDR_WIDTH +: ADDR_WIDTH] = port_en_q[gi]
          ? base_q[gi*ADDR_WIDTH +: ADDR_WIDTH] + ADDR_WIDTH'(lane_off)
          : base_q[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      addr_out_q <= '0;
      port_en_q  <= '0;
      cnt_q      <= '0;
      last_idx_q <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef VREG_AGU_WIDEN_EN
      wide_q     <= '0;
      half_q     <= 1'b0;
`endif
    end else begin
      err_q <= accept_d && !req_legal_d;
      if (accept_d && req_legal_d) begin
        state_q    <= S_BUSY;
        base_q     <= bus.addr_in;
        addr_out_q <= bus.addr_in;
        port_en_q  <= bus.port_en;
        cnt_q      <= '0;
        last_idx_q <= req_last_idx_d;
        first_q    <= 1'b1;
        last_q     <= (req_last_idx_d == '0);
`ifdef VREG_AGU_WIDEN_EN
        wide_q     <= req_wide_d;
        half_q     <= any_wide_d;
`endif
      end else if (beat_take_d) begin
        // An illegal request can only be accepted here alongside the last beat.
        if (last_q) begin
          state_q <= S_IDLE;
          first_q <= 1'b0;
          last_q  <= 1'b0;
        end else begin
          cnt_q      <= cnt_inc_d;
          addr_out_q <= addr_adv_d;
          first_q    <= 1'b0;
          last_q     <= (cnt_inc_d == last_idx_q);
        end
      end
    end
  end

  assign bus.out_valid      = (state_q == S_BUSY);
  assign bus.addr_out       = addr_out_q;
  assign bus.out_port_en    = port_en_q;
  assign bus.out_first      = first_q;
  assign bus.out_last       = last_q;
  assign bus.err_misaligned = err_q;
  assign bus.idle           = (state_q == S_IDLE) && !err_q;
endmodule

// File: tb/tb_vreg_group_addr_gen.sv
// Bench for vreg_group_addr_gen: directed scenarios plus random traffic, checked every cycle
// against a queue-of-expected-beats model built from the group/alignment arithmetic.
module tb_vreg_group_addr_gen;
  localparam int AW = 5;
  localparam int NP = 3;

  logic clk;
  logic rst_ni;
  int   n_checks = 0;
  int   n_errors = 0;

  vreg_group_addr_gen_if #(.ADDR_WIDTH(AW), .NUM_PORTS(NP)) bus ();

  vreg_group_addr_gen #(.ADDR_WIDTH(AW), .NUM_PORTS(NP), .CNT_WIDTH(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NP*AW-1:0] addr;
    logic [NP-1:0]    en;
    bit               first;
    bit               last;
  } beat_t;

  beat_t exp_q[$];
  bit    err_pend = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: expand a request into its full list of beats, or flag it illegal.
  function automatic bit model_accept(input logic [2:0] vl, input logic [NP*AW-1:0] addr,
                                      input logic [NP-1:0] en, input logic [NP-1:0] wid);
    int  unit, n, g, off, a;
    bit  anyw, legal;
    beat_t b;
    unit  = (vl < 4) ? (1 << vl) : 1;
    anyw  = |(wid & en);
    n     = (vl < 4 && anyw) ? 2 * unit : unit;
    legal = (vl != 4) && !(vl == 3 && anyw);
    for (int p = 0; p < NP; p++) begin
      if (en[p]) begin
        g = (vl < 4 && wid[p]) ? 2 * unit : unit;
        if ((int'(addr[p*AW +: AW]) % g) != 0) legal = 0;
      end
    end
    if (legal) begin
      for (int k = 0; k < n; k++) begin
        for (int p = 0; p < NP; p++) begin
          off = (!anyw || wid[p]) ? k : k / 2;
          a   = int'(addr[p*AW +: AW]) + (en[p] ? off : 0);
          b.addr[p*AW +: AW] = AW'(a % (1 << AW));
        end
        b.en    = en;
        b.first = (k == 0);
        b.last  = (k == n - 1);
        exp_q.push_back(b);
      end
    end
    $display("REQ vlmul=%0d addr=%h en=%b wid=%b beats=%0d legal=%0d", vl, addr, en, wid, n, legal);
    return legal;
  endfunction

  // Per-cycle monitor, sampled on the falling edge.
  initial begin
    bit exp_valid, exp_rdy, err_next;
    logic [NP-1:0] wid;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_idle", bus.idle, 1);
        chk("rst_addr_out", bus.addr_out, 0);
      end else begin
        exp_valid = (exp_q.size() != 0);
        chk("out_valid", bus.out_valid, exp_valid);
        if (exp_valid) begin
          chk("addr_out", bus.addr_out, exp_q[0].addr);
          chk("out_port_en", bus.out_port_en, exp_q[0].en);
          chk("out_first", bus.out_first, exp_q[0].first);
          chk("out_last", bus.out_last, exp_q[0].last);
        end
        exp_rdy = !exp_valid || (bus.out_ready && exp_q[0].last);
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("err_misaligned", bus.err_misaligned, err_pend);
        chk("idle", bus.idle, !exp_valid && !err_pend);
        if (exp_valid && bus.out_ready) void'(exp_q.pop_front());
        err_next = 0;
        if (bus.in_valid && exp_rdy) begin
`ifdef VREG_AGU_WIDEN_EN
          wid = bus.widen;
`else
          wid = '0;
`endif
          err_next = !model_accept(bus.vlmul, bus.addr_in, bus.port_en, wid);
        end
        err_pend = err_next;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit v, input logic [2:0] vl, input int a0, input int a1,
                         input int a2, input logic [NP-1:0] en, input logic [NP-1:0] wid);
    bus.in_valid = v;
    bus.vlmul    = vl;
    bus.addr_in  = {AW'(a2), AW'(a1), AW'(a0)};
    bus.port_en  = en;
`ifdef VREG_AGU_WIDEN_EN
    bus.widen    = wid;
`else
    if (wid != '0) $display("note: widen ignored in this build");
`endif
  endtask

  task automatic drain(input int cycles);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (cycles) step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int vl, unit, a[NP];
    rst_ni = 1'b0;
    bus.out_ready = 1'b1;
    set_req(0, 3'd0, 0, 0, 0, '0, '0);
    repeat (2) step();
    rst_ni = 1'b1;
    step();

    // 4-beat group, continuous ready.
    set_req(1, 3'd2, 8, 4, 12, 3'b111, '0);
    step();
    drain(8);

    // 2-beat group stalled 3 cycles on beat 1, with a 1-beat request queued behind it.
    set_req(1, 3'd1, 2, 0, 4, 3'b111, '0);
    step();
    bus.out_ready = 1'b0;
    set_req(1, 3'd0, 20, 21, 22, 3'b111, '0);
    repeat (3) step();
    bus.out_ready = 1'b1;
    step();
    step();
    bus.in_valid = 1'b0;
    drain(6);

    // Misaligned enabled port, then the same request with that port disabled.
    set_req(1, 3'd3, 0, 9, 16, 3'b111, '0);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    set_req(1, 3'd3, 0, 9, 16, 3'b101, '0);
    step();
    drain(12);

    // Reserved vlmul.
    set_req(1, 3'd4, 0, 0, 0, 3'b111, '0);
    step();
    drain(3);

`ifdef VREG_AGU_WIDEN_EN
    set_req(1, 3'd1, 2, 6, 4, 3'b111, 3'b100);
    step();
    drain(8);
`endif

    // Asynchronous reset during beat 2 of 4.
    set_req(1, 3'd2, 8, 4, 12, 3'b111, '0);
    step();
    bus.in_valid = 1'b0;
    step();
    #2;
    rst_ni = 1'b0;
    exp_q.delete();
    err_pend = 0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_addr", bus.addr_out, 0);
    chk("async_rst_first", bus.out_first, 0);
    chk("async_rst_last", bus.out_last, 0);
    chk("async_rst_idle", bus.idle, 1);
    step();
    rst_ni = 1'b1;
    set_req(1, 3'd0, 1, 2, 3, 3'b111, '0);
    step();
    drain(4);

    // Random traffic, mostly aligned, with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      vl   = $urandom_range(0, 7);
      unit = (vl < 4) ? (1 << vl) : 1;
      for (int p = 0; p < NP; p++) begin
        a[p] = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31)
                                           : ($urandom_range(0, 31) / unit) * unit;
      end
      set_req($urandom_range(0, 9) < 6, 3'(vl), a[0], a[1], a[2], 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain(40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
